// File: rtl/tinyrv_pkg.sv
// tinyrv shared definitions: ALU op encodings, funct3 codes,
// FSM state encoding and datapath width.
package tinyrv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_WRITE = S_WRITE
  } state_e;

  // Ops that run the adder as rs1 + ~rs2 + 1.
  function automatic logic uses_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op[2:0] == F3_SLT)
        || (op[2:0] == F3_SLTU);
  endfunction

endpackage

// File: rtl/serial_alu_shifter.sv
// Combinational 32-bit barrel shifter for the serial ALU.
// dir=0 shifts left; dir=1 shifts right, sign-filling when arith.
module serial_alu_shifter (
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        arith,
  output logic [31:0] result
);

  always_comb begin
    result = data << shamt;
    if (dir) begin
      if (arith) result = $unsigned($signed(data) >>> shamt);
      else       result = data >> shamt;
    end
  end

endmodule

// File: rtl/serial_alu.sv
// Byte-serial RV32I ALU: operands arrive LSB first over four
// mux_phase beats, the result leaves over the next four.
module serial_alu #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mux_phase,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] rs1_dat,
  input  logic [7:0] rs2_dat,
  output logic [7:0] rd_dat,
  output logic       rd_we,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import tinyrv_pkg::*;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [1:0]      beat_q, beat_d;
  logic            carry_q, carry_d;
  logic [4:0]      shamt_q, shamt_d;
  logic [XLEN-9:0] a_q, a_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [7:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic            err_q, err_d;

  logic            accept, abort, cin;
  logic [3:0]      cur_op;
  logic [1:0]      idx;
  logic [7:0]      b_byte, byte_res;
  logic [8:0]      sum;
  logic            slt_flag, sltu_flag;
  logic [XLEN-1:0] a_full, sh_out, final_res;

  assign a_full = {rs1_dat, a_q};

  serial_alu_shifter u_shifter (
    .data   (a_full),
    .shamt  (shamt_q),
    .dir    (op_q[2:0] == F3_SR),
    .arith  (op_q[3]),
    .result (sh_out)
  );

  always_comb begin
    accept = (state_q == ST_IDLE) && start
          && (mux_phase == 2'd0);
    abort  = (state_q != ST_IDLE) && (mux_phase != beat_q);
    cur_op = accept ? op : op_q;
    idx    = accept ? 2'd0 : beat_q;
    cin    = accept ? uses_sub(op) : carry_q;
    b_byte = uses_sub(cur_op) ? ~rs2_dat : rs2_dat;
    sum    = {1'b0, rs1_dat} + {1'b0, b_byte} + {8'd0, cin};
    case (cur_op[2:0])
      F3_XOR:  byte_res = rs1_dat ^ rs2_dat;
      F3_OR:   byte_res = rs1_dat | rs2_dat;
      F3_AND:  byte_res = rs1_dat & rs2_dat;
      default: byte_res = sum[7:0];
    endcase
    // Byte 3 is still on the bus at the LOAD->WRITE edge.
    slt_flag  = (rs1_dat[7] != rs2_dat[7]) ? rs1_dat[7] : sum[7];
    sltu_flag = ~sum[8];
    case (op_q[2:0])
      F3_SLL, F3_SR: final_res = sh_out;
      F3_SLT:        final_res = {{(XLEN-1){1'b0}}, slt_flag};
      F3_SLTU:       final_res = {{(XLEN-1){1'b0}}, sltu_flag};
      default:       final_res = {byte_res, res_q[XLEN-9:0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    beat_d  = beat_q;
    carry_d = carry_q;
    shamt_d = shamt_q;
    a_d     = a_q;
    res_d   = res_q;
    rd_d    = 8'd0;
    we_d    = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_LOAD;
          op_d         = op;
          beat_d       = 2'd1;
          shamt_d      = rs2_dat[4:0];
          carry_d      = sum[8];
          a_d[7:0]     = rs1_dat;
          res_d[7:0]   = byte_res;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          beat_d  = beat_q + 2'd1;
          carry_d = sum[8];
          if (beat_q != 2'd3) begin
            a_d[{idx, 3'b000} +: 8]   = rs1_dat;
            res_d[{idx, 3'b000} +: 8] = byte_res;
          end else begin
            state_d = ST_WRITE;
            res_d   = final_res;
            rd_d    = final_res[7:0];
            we_d    = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          beat_d = beat_q + 2'd1;
          if (beat_q != 2'd3) begin
            rd_d  = res_q[15:8];
            we_d  = 1'b1;
            res_d = res_q >> 8;
          end else begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      beat_q  <= 2'd0;
      carry_q <= 1'b0;
      shamt_q <= 5'd0;
      a_q     <= '0;
      res_q   <= '0;
      rd_q    <= 8'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      beat_q  <= beat_d;
      carry_q <= carry_d;
      shamt_q <= shamt_d;
      a_q     <= a_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign rd_dat = rd_q;
  assign rd_we  = we_q;
  assign err    = err_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: directed table, random ops against an
// arithmetic reference model, and phase/reset corner sequences.
module tb_serial_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mux_phase;
  logic       start;
  logic [3:0] op;
  logic [7:0] rs1_dat, rs2_dat, rd_dat;
  logic       rd_we, busy, done, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .mux_phase(mux_phase),
    .start(start), .op(op),
    .rs1_dat(rs1_dat), .rs2_dat(rs2_dat),
    .rd_dat(rd_dat), .rd_we(rd_we), .busy(busy),
    .done(done), .err(err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (o[2:0])
      3'd0: return o[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return o[3] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
    mux_phase = mux_phase + 2'd1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input bit hold);
    logic [31:0] got;
    int nwe, ndone, nbad;
    got = 0; nwe = 0; ndone = 0; nbad = 0;
    while (mux_phase != 2'd0) next_cyc();
    for (int c = 0; c < 8; c++) begin
      start   = hold || (c == 0);
      op      = (c == 0) ? o : 4'($urandom);
      rs1_dat = (c < 4) ? a[8*c +: 8] : 8'($urandom);
      rs2_dat = (c < 4) ? b[8*c +: 8] : 8'($urandom);
      #4;
      if (c >= 4) begin
        if (rd_we) begin
          got[8*(c-4) +: 8] = rd_dat;
          nwe++;
        end
      end else if (rd_we || rd_dat != 8'd0) nbad++;
      if (c >= 1 && !busy) nbad++;
      if (c == 0 && busy) nbad++;
      if (done) ndone += (c == 7) ? 1 : 100;
      if (err) nbad++;
      next_cyc();
    end
    start = 1'b0;
    #4;
    check("result", got, exp);
    check("we_beats", nwe, 4);
    check("done_pulse", ndone, 1);
    check("beat_timing", nbad, 0);
    check("idle_after", {31'd0, busy}, 0);
  endtask

  initial begin
    int cnt, errs, wes;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{4'b0000, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100};
    tbl[1]  = '{4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    tbl[2]  = '{4'b0011, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
    tbl[3]  = '{4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    tbl[4]  = '{4'b1101, 32'h8000_0010, 32'h0000_0024, 32'hF800_0001};
    tbl[5]  = '{4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
    tbl[6]  = '{4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
    tbl[7]  = '{4'b1100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB};
    tbl[8]  = '{4'b1001, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030};
    tbl[9]  = '{4'b0011, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    tbl[10] = '{4'b0010, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    tbl[11] = '{4'b1111, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'h0E0D_B0E0};

    rst = 1'b1; mux_phase = 2'd0; start = 1'b0; op = 4'd0;
    rs1_dat = 8'd0; rs2_dat = 8'd0;
    next_cyc();
    next_cyc();
    #4;
    check("reset_outs", {27'd0, rd_dat, rd_we, busy, done, err}, 0);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 0);

    // start held high across a whole op must not double-issue
    run_op(4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1);

    // start at phase 2 is ignored
    while (mux_phase != 2'd2) next_cyc();
    start = 1'b1; op = 4'b0000;
    next_cyc();
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      #4;
      if (busy || rd_we || done) cnt++;
      next_cyc();
    end
    check("start_phase2_ignored", cnt, 0);

    // phase skip 1->3 during LOAD aborts with err
    while (mux_phase != 2'd0) next_cyc();
    start = 1'b1; op = 4'b1000; rs1_dat = 8'h55; rs2_dat = 8'h11;
    next_cyc();
    start = 1'b0;
    next_cyc();
    mux_phase = 2'd3;
    #4;
    errs = err ? 1 : 0;
    wes = 0;
    next_cyc();
    #4;
    check("skip_err_pulse", {31'd0, err}, 1);
    check("skip_busy_clear", {31'd0, busy}, 0);
    for (int c = 0; c < 9; c++) begin
      if (err) errs++;
      if (rd_we) wes++;
      next_cyc();
      #4;
    end
    check("skip_err_count", errs, 1);
    check("skip_no_we", wes, 0);

    // reset at T+5 of an ADD
    while (mux_phase != 2'd0) next_cyc();
    for (int c = 0; c < 6; c++) begin
      start = (c == 0); op = 4'b0000;
      rs1_dat = 8'hA5; rs2_dat = 8'h5A;
      rst = (c == 5);
      if (c < 5) next_cyc();
    end
    next_cyc();
    rst = 1'b0;
    #4;
    check("midop_reset_outs",
          {27'd0, rd_dat, rd_we, busy, done, err}, 0);
    wes = 0;
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      #4;
      if (rd_we || busy) wes++;
    end
    check("midop_reset_quiet", wes, 0);
    run_op(4'b0000, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = rb & 32'h8000_001F;
      run_op(ro, ra, rb, ref_alu(ro, ra, rb), (i % 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
